// File: rtl/demux16_1_deser_if.sv
// demux16_1_deser_if
//   Bundles the serial input side and the parallel output side of the
//   16:1 deserialiser.
//   slave  : the deserialiser (consumes the bit stream, produces words)
//   master : the environment (drives bits, accepts words)
//   Signals: in_bit/in_valid/in_sof/in_ready  serial beat handshake
//            s/slot_strobe/slot_bit           demux select and per-slot pulse
//            out/out_valid/out_ready          parallel word handshake
//            frame_err                        truncated-frame pulse
interface demux16_1_deser_if;
  logic        in_bit;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [3:0]  s;
  logic [15:0] slot_strobe;
  logic        slot_bit;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;

  modport slave (
    input  in_bit, in_valid, in_sof, out_ready,
    output in_ready, s, slot_strobe, slot_bit, out, out_valid, frame_err
  );

  modport master (
    output in_bit, in_valid, in_sof, out_ready,
    input  in_ready, s, slot_strobe, slot_bit, out, out_valid, frame_err
  );
endinterface

// File: rtl/demux16_1_deser.sv
// demux16_1_deser
//   Serial-to-parallel receiver for the 16:1 serialiser. A 4-bit slot
//   counter steers each accepted bit into its word position, LSB first.
//   After 16 bits the word is held on a valid/ready port until taken.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  demux16_1_deser_if.slave (serial in, parallel out, status)
module demux16_1_deser (
  input  logic                  clk,
  input  logic                  rst,
  demux16_1_deser_if.slave      bus
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_s;
  // Slot 15 never needs storage: the last bit goes straight into the word.
  logic [14:0] r_shreg;
  logic [15:0] r_out;
  logic [15:0] r_strobe;
  logic        r_out_valid;
  logic        r_slot_bit;
  logic        r_frame_err;
  logic        w_ready;
  logic        w_accept;

  assign w_accept = bus.in_valid && w_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_next;
  end

  // Next-state logic; an SOF beat at slot 15 restarts instead of completing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL: if (w_accept && !bus.in_sof && (r_s == 4'hF)) w_next = HOLD;
      HOLD: if (r_out_valid && bus.out_ready)             w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  // Output logic; ready drops during reset so no beat is lost to it.
  always_comb begin
    w_ready = (r_state == FILL) && !rst;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s         <= 4'd0;
      r_shreg     <= 15'd0;
      r_out       <= 16'd0;
      r_out_valid <= 1'b0;
      r_strobe    <= 16'd0;
      r_slot_bit  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_strobe    <= 16'd0;
      r_frame_err <= 1'b0;
      if (w_accept) begin
        r_slot_bit <= bus.in_bit;
        if (bus.in_sof) begin
          // New frame: bit lands in slot 0, stale slots get overwritten later.
          r_shreg[0]  <= bus.in_bit;
          r_s         <= 4'd1;
          r_strobe    <= 16'h0001;
          r_frame_err <= (r_s != 4'd0);
        end else begin
          r_strobe <= 16'(1) << r_s;
          r_s      <= r_s + 4'd1;
          if (r_s == 4'hF) begin
            r_out       <= {bus.in_bit, r_shreg};
            r_out_valid <= 1'b1;
          end else begin
            r_shreg[r_s] <= bus.in_bit;
          end
        end
      end
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.s           = r_s;
  assign bus.slot_strobe = r_strobe;
  assign bus.slot_bit    = r_slot_bit;
  assign bus.out         = r_out;
  assign bus.out_valid   = r_out_valid;
  assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_demux16_1_deser.sv
module tb_demux16_1_deser;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;

  demux16_1_deser_if bus();

  demux16_1_deser dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accepted beat; waits (bounded) while the block is not ready.
  task automatic beat(input logic b, input logic sof);
    logic rdy;
    int   guard;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_sof   = sof;
    rdy   = 1'b0;
    guard = 0;
    while (!rdy) begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      guard++;
      if (!rdy && guard > 50) begin
        n_tests++;
        n_fail++;
        $error("FAIL beat_timeout: got no ready expected ready within 50 cycles");
        rdy = 1'b1;
      end
    end
    bus.in_sof = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit chk_sb);
    for (int i = 0; i < 16; i++) begin
      beat(w[i], 1'b0);
      if (chk_sb) begin
        chk("walk_strobe", 32'(bus.slot_strobe), 32'(16'h0001 << i));
        chk("walk_bit",    32'(bus.slot_bit),    32'(w[i]));
      end
    end
  endtask

  initial begin
    logic [39:0] gp;
    logic [15:0] gw;
    logic [3:0]  exp_s;
    int          k;
    int          ev;
    int          t1;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    bus.in_bit = 1'b0; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  32'(bus.in_ready),    32'd0);
    chk("rst_valid",  32'(bus.out_valid),   32'd0);
    chk("rst_out",    32'(bus.out),         32'd0);
    chk("rst_s",      32'(bus.s),           32'd0);
    chk("rst_strobe", 32'(bus.slot_strobe), 32'd0);
    chk("rst_ferr",   32'(bus.frame_err),   32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Basic frame
    bus.out_ready = 1'b1;
    send_word(16'hA5C3, 1'b1);
    bus.in_valid = 1'b0;
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_out",   32'(bus.out),       32'hA5C3);
    chk("basic_hold",  32'(bus.in_ready),  32'd0);
    @(posedge clk); #1;
    chk("basic_done",   32'(bus.out_valid), 32'd0);
    chk("basic_resume", 32'(bus.in_ready),  32'd1);
    chk("basic_keep",   32'(bus.out),       32'hA5C3);
    chk("basic_s0",     32'(bus.s),         32'd0);

    // Backpressure: beats offered during HOLD must be dropped
    bus.out_ready = 1'b0;
    send_word(16'h5A5A, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = i[0];
      @(posedge clk); #1;
      chk("bp_valid",  32'(bus.out_valid),   32'd1);
      chk("bp_out",    32'(bus.out),         32'h5A5A);
      chk("bp_ready",  32'(bus.in_ready),    32'd0);
      chk("bp_strobe", 32'(bus.slot_strobe), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done",  32'(bus.out_valid), 32'd0);
    chk("bp_ready", 32'(bus.in_ready),  32'd1);
    chk("bp_s",     32'(bus.s),         32'd0);

    // Gappy input
    gp = 40'hA56C93D2B7;
    gw = 16'h1234;
    exp_s = 4'd0;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (k < 16) begin
        bus.in_valid = gp[c];
        bus.in_bit   = gw[k];
        @(posedge clk); #1;
        if (gp[c]) begin
          k++;
          exp_s = exp_s + 4'd1;
        end
        chk("gap_s", 32'(bus.s), 32'(exp_s));
      end
    end
    bus.in_valid = 1'b0;
    chk("gap_valid", 32'(bus.out_valid), 32'd1);
    chk("gap_out",   32'(bus.out),       32'h1234);
    @(posedge clk); #1;

    // SOF truncation after 7 bits
    for (int i = 0; i < 7; i++) beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    chk("sof_err",    32'(bus.frame_err),   32'd1);
    chk("sof_strobe", 32'(bus.slot_strobe), 32'h0001);
    chk("sof_s",      32'(bus.s),           32'd1);
    ev = 0;
    for (int i = 0; i < 15; i++) begin
      beat(1'b1, 1'b0);
      if (i == 0) chk("sof_err_pulse", 32'(bus.frame_err), 32'd0);
      if (i < 14 && bus.out_valid) ev++;
    end
    chk("sof_no_early_word", 32'(ev), 32'd0);
    chk("sof_valid", 32'(bus.out_valid), 32'd1);
    chk("sof_out",   32'(bus.out),       32'hFFFF);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // SOF at slot 0 is legal; SOF at slot 15 restarts without emitting
    beat(1'b0, 1'b1);
    chk("sof0_err", 32'(bus.frame_err), 32'd0);
    chk("sof0_s",   32'(bus.s),         32'd1);
    for (int i = 0; i < 14; i++) beat(1'b0, 1'b0);
    chk("sof15_pre_s", 32'(bus.s), 32'd15);
    beat(1'b1, 1'b1);
    chk("sof15_err",   32'(bus.frame_err), 32'd1);
    chk("sof15_valid", 32'(bus.out_valid), 32'd0);
    chk("sof15_s",     32'(bus.s),         32'd1);
    for (int i = 0; i < 15; i++) beat(1'b0, 1'b0);
    chk("sof15_out",   32'(bus.out),       32'h0001);
    chk("sof15_vld",   32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset mid-frame
    for (int i = 0; i < 9; i++) beat(1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("mrst_s",      32'(bus.s),           32'd0);
    chk("mrst_out",    32'(bus.out),         32'd0);
    chk("mrst_valid",  32'(bus.out_valid),   32'd0);
    chk("mrst_strobe", 32'(bus.slot_strobe), 32'd0);
    chk("mrst_bit",    32'(bus.slot_bit),    32'd0);
    chk("mrst_ferr",   32'(bus.frame_err),   32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mrst_ready_after", 32'(bus.in_ready), 32'd1);
    send_word(16'h00FF, 1'b0);
    bus.in_valid = 1'b0;
    chk("mrst_word",  32'(bus.out),       32'h00FF);
    chk("mrst_wvld",  32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

    // Reset during HOLD
    bus.out_ready = 1'b0;
    send_word(16'h0F0F, 1'b0);
    bus.in_valid = 1'b0;
    chk("hrst_pre", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("hrst_valid", 32'(bus.out_valid), 32'd0);
    chk("hrst_out",   32'(bus.out),       32'd0);
    rst = 1'b0;
    #1;
    chk("hrst_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back frames
    bus.out_ready = 1'b1;
    send_word(16'hFFFF, 1'b0);
    chk("b2b_out1", 32'(bus.out),       32'hFFFF);
    chk("b2b_vld1", 32'(bus.out_valid), 32'd1);
    chk("b2b_wrap", 32'(bus.s),         32'd0);
    t1 = cyc;
    send_word(16'h0001, 1'b0);
    bus.in_valid = 1'b0;
    chk("b2b_out2", 32'(bus.out),       32'h0001);
    chk("b2b_vld2", 32'(bus.out_valid), 32'd1);
    chk("b2b_gap",  32'(cyc - t1),      32'd17);
    @(posedge clk); #1;
    chk("b2b_done", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/demux16_1_deser.md
# demux16_1_deser

Serial-to-parallel demultiplexer: the receive end of the 16:1 select/serialise path. A serial bit stream arrives one bit per accepted beat. An internal 4-bit slot counter acts as the demux select and steers each bit into output bit position `slot`, LSB (slot 0) first. After 16 accepted bits, the assembled 16-bit word is presented on a valid/ready output port. The block sits directly downstream of the 16:1 mux serialiser and rebuilds the word that was fed into `in[15:0]`.

## Interface
No parameters. Width is fixed at 16 bits and the select is fixed at 4 bits.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_bit`  in  1  serial data bit.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_sof`  in  1  start-of-frame marker; qualified by `in_valid`.
- `in_ready`  out  1  block can accept a bit this cycle.
- `s`  out  4  current demux select, i.e. the slot the next accepted bit is written to.
- `slot_strobe`  out  16  registered one-hot demux output: bit `k` pulses for one cycle after a bit is accepted into slot `k`.
- `slot_bit`  out  1  registered copy of the last accepted bit, aligned with `slot_strobe`.
- `out`  out  16  assembled parallel word.
- `out_valid`  out  1  `out` holds a complete frame.
- `out_ready`  in  1  downstream accepts `out`.
- `frame_err`  out  1  one-cycle pulse when a frame is truncated by `in_sof`.

## Operation
- The state machine has two states, FILL and HOLD.
- `in_ready` = (state == FILL) and not `rst`. It is combinational from the state register.
- An input beat is accepted when `in_valid` and `in_ready` are both high.
- FILL, accept without `in_sof`:
  - `shreg[s]` <= `in_bit`.
  - `s` <= `s` + 1; 4-bit arithmetic, wrapping 15 -> 0.
- FILL, accept with `in_sof`:
  - `shreg[0]` <= `in_bit`.
  - `s` <= 1.
  - Bits of the partial frame at slots ≥1 are stale and are overwritten as the new frame fills.
  - If `s` != 0 at acceptance, `frame_err` pulses next cycle.
  - `in_sof` with `s` == 0 is legal and raises no error.
- FILL, accept at `s` == 15 (without `in_sof`):
  - `out` <= {`in_bit`, `shreg[14:0]`}.
  - `out_valid` <= 1; `s` <= 0; state <= HOLD.
- HOLD:
  - `in_ready` = 0. `in_valid` and `in_sof` are ignored and no strobe is generated.
  - On `out_valid` and `out_ready`: `out_valid` <= 0, state <= FILL.
  - `out` keeps its last value after the handshake until the next frame completes.
- On each acceptance, `slot_strobe` <= one-hot(`s` before increment; 0 for an `in_sof` beat) and `slot_bit` <= `in_bit`. Otherwise `slot_strobe` <= 0.
- Reset, including mid-frame or mid-HOLD, clears:
  - state -> FILL, `s` -> 0, `shreg` -> 0.
  - `out` -> 0, `out_valid` -> 0.
  - `slot_strobe` -> 0, `slot_bit` -> 0, `frame_err` -> 0.
  - The partial frame is discarded. `in_ready` is 0 during the reset cycle and 1 on the first cycle after.

## Timing
- Latency: `out_valid` rises on the cycle after the 16th acceptance.
- Minimum frame period is 17 cycles: 16 accept cycles plus 1 HOLD cycle with `out_ready` held high.
- `slot_strobe`, `slot_bit` and `frame_err` lag their acceptance by one cycle and are single-cycle pulses.
- `out_valid` must not drop without an `out_ready` handshake. `out` must be stable while `out_valid` is high.
- Gaps in `in_valid` stall the counter. `s` and `shreg` hold their values.
- `in_sof` on the same beat as `s` == 15 takes priority: the frame restarts, `frame_err` pulses, and no word is emitted.

## Test plan
- **Basic frame:** reset, then 16 consecutive beats carrying 16'hA5C3 LSB first, with `out_ready`=1.
  - `out_valid`=1 with `out`=16'hA5C3 exactly 1 cycle after beat 16.
  - `in_ready`=0 for one cycle, then 1.
  - `slot_strobe` walks 16'h0001 -> 16'h8000.
- **Backpressure:** complete a frame with `out_ready`=0 for 10 cycles.
  - `out_valid` and `out` stay constant and `in_ready` stays 0.
  - Beats offered during HOLD are dropped.
  - Raising `out_ready` gives one handshake, and FILL resumes the next cycle.
- **Gappy input:** send 16'h1234 with `in_valid` toggling randomly.
  - `out`=16'h1234.
  - `s` never advances on a non-accept cycle.
- **SOF truncation:** 7 bits, then an `in_sof` beat, then 15 more bits forming 16'hFFFF.
  - `frame_err` pulses once, 1 cycle after the `in_sof` beat.
  - `out`=16'hFFFF.
  - No word is emitted for the truncated frame.
- **Reset mid-operation:** assert `rst` after 9 beats, then send a full 16'h00FF frame.
  - All outputs are 0 during and after the reset cycle.
  - The next word is 16'h00FF, with no stale bits from before reset.
  - Repeat with `rst` asserted during HOLD: `out_valid` drops immediately.
- **Wrap / back-to-back:** two consecutive frames, 16'hFFFF then 16'h0001, with `out_ready`=1.
  - Both words are emitted, 17 cycles apart.
  - `s` wraps to 0 between the frames.
